// File: rtl/ysyx_22050854_lsu_multibeat.sv
// ysyx_22050854_lsu_multibeat: multi-beat load/store unit between execute stage and a handshaked memory bus
module ysyx_22050854_lsu_multibeat #(
    parameter int XLEN = 64,
    parameter int ADDR_W = 64,
    parameter int BUS_W = 64,
    parameter logic [ADDR_W-1:0] MEM_BASE = ADDR_W'(64'h80000000)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_wr_i,
    input  logic [2:0]           req_op_i,
    input  logic [ADDR_W-1:0]    req_addr_i,
    input  logic [XLEN-1:0]      req_wdata_i,
    output logic                 resp_valid_o,
    input  logic                 resp_ready_i,
    output logic [XLEN-1:0]      resp_rdata_o,
    output logic                 resp_err_o,
    output logic                 bus_valid_o,
    input  logic                 bus_ready_i,
    output logic                 bus_wr_o,
    output logic [ADDR_W-1:0]    bus_addr_o,
    output logic [BUS_W-1:0]     bus_wdata_o,
    output logic [BUS_W/8-1:0]   bus_wstrb_o,
    input  logic                 bus_rvalid_i,
    input  logic [BUS_W-1:0]     bus_rdata_i
);
    localparam int NB = BUS_W / 8;
    localparam int LW = $clog2(NB);
    localparam int BTW = $clog2(XLEN / BUS_W + 1);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
    state_t state_q, state_d;
    logic wr_q, wr_d, err_q, err_d;
    logic [2:0] op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d, buf_q, buf_d, sh, ext;
    logic [BTW-1:0] beat_q, beat_d;
    logic [7:0] size_req, size_cur;
    logic [15:0] mask;
    logic [LW-1:0] lane;
    logic bad_req, last, sx;
    assign size_req = 8'd1 << req_op_i[1:0];
    assign size_cur = 8'd1 << op_q[1:0];
    assign bad_req = req_op_i == 3'b111 || (req_wr_i && req_op_i[2]) || |(req_addr_i & ADDR_W'(size_req - 8'd1));
    assign last = (32'(beat_q) + 32'd1) * NB >= 32'(size_cur);
    assign lane = addr_q[LW-1:0];
    assign mask = (16'd1 << size_cur) - 16'd1;
    assign req_ready_o = rst && state_q == IDLE;
    assign resp_valid_o = rst && state_q == RESP;
    assign resp_err_o = rst && state_q == RESP && err_q;
    assign bus_valid_o = rst && state_q == REQ;
    assign bus_wr_o = wr_q;
    // Split beats are size-aligned, so their lane is always zero.
    assign bus_addr_o = (addr_q & ~ADDR_W'(NB - 1)) + ADDR_W'(32'(beat_q) * NB);
    assign bus_wdata_o = BUS_W'(wdata_q >> (32'(beat_q) * BUS_W)) << {lane, 3'b000};
    assign bus_wstrb_o = wr_q ? NB'(mask) << lane : '0;
    assign sh = buf_q >> {lane, 3'b000};
    assign sx = ~op_q[2];
    assign ext = op_q[1:0] == 2'd0 ? {{(XLEN-8){sx & sh[7]}}, sh[7:0]} :
                 op_q[1:0] == 2'd1 ? {{(XLEN-16){sx & sh[15]}}, sh[15:0]} :
                 op_q[1:0] == 2'd2 ? {{(XLEN-32){sx & sh[31]}}, sh[31:0]} : sh;
    assign resp_rdata_o = (state_q == RESP && !wr_q && !err_q) ? ext : '0;
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            wr_q <= 1'b0;
            err_q <= 1'b0;
            op_q <= '0;
            addr_q <= '0;
            wdata_q <= '0;
            buf_q <= '0;
            beat_q <= '0;
        end else begin
            state_q <= state_d;
            wr_q <= wr_d;
            err_q <= err_d;
            op_q <= op_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
            buf_q <= buf_d;
            beat_q <= beat_d;
        end
    end
    always_comb begin
        state_d = state_q;
        wr_d = wr_q;
        err_d = err_q;
        op_d = op_q;
        addr_d = addr_q;
        wdata_d = wdata_q;
        buf_d = buf_q;
        beat_d = beat_q;
        case (state_q)
            IDLE: if (req_valid_i) begin
                wr_d = req_wr_i;
                op_d = req_op_i;
                addr_d = req_addr_i;
                wdata_d = req_wdata_i;
                buf_d = '0;
                beat_d = '0;
                err_d = bad_req;
                state_d = (bad_req || req_addr_i < MEM_BASE) ? RESP : REQ;
            end
            REQ: if (bus_ready_i) begin
                state_d = !wr_q ? WAIT : last ? RESP : REQ;
                beat_d = wr_q ? beat_q + 1'b1 : beat_q;
            end
            // Buffer is cleared on accept and each beat lands once, so OR-merge suffices.
            WAIT: if (bus_rvalid_i) begin
                buf_d = buf_q | (XLEN'(bus_rdata_i) << (32'(beat_q) * BUS_W));
                state_d = last ? RESP : REQ;
                beat_d = beat_q + 1'b1;
            end
            RESP: if (resp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ysyx_22050854_lsu_multibeat.sv
// tb_ysyx_22050854_lsu_multibeat: directed vector bench for 64- and 32-bit bus LSU instances
module tb_ysyx_22050854_lsu_multibeat;
    logic clk = 1'b0, rst = 1'b0;
    always #5 clk = ~clk;
    logic sel, req_valid, req_wr, resp_ready, bus_ready, bus_rvalid;
    logic [2:0] req_op;
    logic [63:0] req_addr, req_wdata, bus_rdata;
    logic a_req_ready, a_resp_valid, a_resp_err, a_bus_valid, a_bus_wr;
    logic [63:0] a_resp_rdata, a_bus_addr, a_bus_wdata;
    logic [7:0] a_bus_wstrb;
    logic b_req_ready, b_resp_valid, b_resp_err, b_bus_valid, b_bus_wr;
    logic [63:0] b_resp_rdata, b_bus_addr;
    logic [31:0] b_bus_wdata;
    logic [3:0] b_bus_wstrb;
    logic m_req_ready, m_resp_valid, m_resp_err, m_bus_valid, m_bus_wr;
    logic [63:0] m_resp_rdata, m_bus_addr, m_bus_wdata;
    logic [7:0] m_bus_wstrb;
    int n_err = 0, n_chk = 0;

    ysyx_22050854_lsu_multibeat #(.BUS_W(64)) dut64 (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid && !sel), .req_ready_o(a_req_ready), .req_wr_i(req_wr),
        .req_op_i(req_op), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .resp_valid_o(a_resp_valid), .resp_ready_i(resp_ready), .resp_rdata_o(a_resp_rdata),
        .resp_err_o(a_resp_err), .bus_valid_o(a_bus_valid), .bus_ready_i(bus_ready),
        .bus_wr_o(a_bus_wr), .bus_addr_o(a_bus_addr), .bus_wdata_o(a_bus_wdata),
        .bus_wstrb_o(a_bus_wstrb), .bus_rvalid_i(bus_rvalid), .bus_rdata_i(bus_rdata));

    ysyx_22050854_lsu_multibeat #(.BUS_W(32)) dut32 (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid && sel), .req_ready_o(b_req_ready), .req_wr_i(req_wr),
        .req_op_i(req_op), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .resp_valid_o(b_resp_valid), .resp_ready_i(resp_ready), .resp_rdata_o(b_resp_rdata),
        .resp_err_o(b_resp_err), .bus_valid_o(b_bus_valid), .bus_ready_i(bus_ready),
        .bus_wr_o(b_bus_wr), .bus_addr_o(b_bus_addr), .bus_wdata_o(b_bus_wdata),
        .bus_wstrb_o(b_bus_wstrb), .bus_rvalid_i(bus_rvalid), .bus_rdata_i(bus_rdata[31:0]));

    assign m_req_ready = sel ? b_req_ready : a_req_ready;
    assign m_resp_valid = sel ? b_resp_valid : a_resp_valid;
    assign m_resp_err = sel ? b_resp_err : a_resp_err;
    assign m_resp_rdata = sel ? b_resp_rdata : a_resp_rdata;
    assign m_bus_valid = sel ? b_bus_valid : a_bus_valid;
    assign m_bus_wr = sel ? b_bus_wr : a_bus_wr;
    assign m_bus_addr = sel ? b_bus_addr : a_bus_addr;
    assign m_bus_wdata = sel ? {32'h0, b_bus_wdata} : a_bus_wdata;
    assign m_bus_wstrb = sel ? {4'h0, b_bus_wstrb} : a_bus_wstrb;

    typedef struct {
        bit sel; bit wr; logic [2:0] op; logic [63:0] addr, wdata, rd0, rd1, exp_rdata;
        bit exp_err; int exp_lat, exp_beats; logic [63:0] exp_a0, exp_a1; logic [7:0] exp_strb; logic [63:0] exp_wd;
    } vec_t;
    vec_t vt[22];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tk();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int idx, input vec_t v);
        int lat = 0, beats = 0;
        bit done = 0;
        logic [63:0] a0 = '0, a1 = '0, w0 = '0;
        logic [7:0] s0 = '0;
        logic wr0 = 1'b0;
        sel = v.sel; req_wr = v.wr; req_op = v.op; req_addr = v.addr; req_wdata = v.wdata;
        bus_rdata = v.rd0; bus_ready = 1'b1; bus_rvalid = 1'b1; resp_ready = 1'b1; req_valid = 1'b1;
        #1 chk($sformatf("v%0d_req_ready", idx), 64'(m_req_ready), 64'd1);
        tk();
        req_valid = 1'b0;
        for (int c = 1; c <= 20 && !done; c++) begin
            if (m_bus_valid) begin
                if (beats == 0) begin a0 = m_bus_addr; s0 = m_bus_wstrb; w0 = m_bus_wdata; wr0 = m_bus_wr; end
                else a1 = m_bus_addr;
                beats++;
                bus_rdata = beats == 1 ? v.rd0 : v.rd1;
            end
            if (m_resp_valid) begin
                lat = c;
                done = 1;
                chk($sformatf("v%0d_rdata", idx), m_resp_rdata, v.exp_rdata);
                chk($sformatf("v%0d_err", idx), 64'(m_resp_err), 64'(v.exp_err));
            end else tk();
        end
        if (!done) chk($sformatf("v%0d_resp_timeout", idx), 64'd0, 64'd1);
        chk($sformatf("v%0d_latency", idx), 64'(lat), 64'(v.exp_lat));
        chk($sformatf("v%0d_beats", idx), 64'(beats), 64'(v.exp_beats));
        if (beats > 0) begin
            chk($sformatf("v%0d_addr0", idx), a0, v.exp_a0);
            chk($sformatf("v%0d_wstrb", idx), 64'(s0), 64'(v.exp_strb));
            chk($sformatf("v%0d_bus_wr", idx), 64'(wr0), 64'(v.wr));
        end
        if (beats > 1) chk($sformatf("v%0d_addr1", idx), a1, v.exp_a1);
        if (beats > 0 && v.wr) chk($sformatf("v%0d_wdata", idx), w0, v.exp_wd);
        tk();
        chk($sformatf("v%0d_idle_after", idx), {62'd0, m_req_ready, m_resp_valid}, 64'd2);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] d;
        d = 64'h11223344_85667788;
        vt[0]  = '{0, 0, 3'b000, 64'h80000003, 0, d, 0, 64'hFFFFFFFFFFFFFF85, 0, 3, 1, 64'h80000000, 0, 8'h00, 0};
        vt[1]  = '{0, 0, 3'b100, 64'h80000003, 0, d, 0, 64'h85, 0, 3, 1, 64'h80000000, 0, 8'h00, 0};
        vt[2]  = '{0, 0, 3'b001, 64'h80000002, 0, d, 0, 64'hFFFFFFFFFFFF8566, 0, 3, 1, 64'h80000000, 0, 8'h00, 0};
        vt[3]  = '{0, 0, 3'b101, 64'h80000006, 0, d, 0, 64'h1122, 0, 3, 1, 64'h80000000, 0, 8'h00, 0};
        vt[4]  = '{0, 0, 3'b010, 64'h80000004, 0, d, 0, 64'h11223344, 0, 3, 1, 64'h80000000, 0, 8'h00, 0};
        vt[5]  = '{0, 0, 3'b010, 64'h80000000, 0, d, 0, 64'hFFFFFFFF85667788, 0, 3, 1, 64'h80000000, 0, 8'h00, 0};
        vt[6]  = '{0, 0, 3'b110, 64'h80000000, 0, d, 0, 64'h85667788, 0, 3, 1, 64'h80000000, 0, 8'h00, 0};
        vt[7]  = '{0, 0, 3'b011, 64'h80000008, 0, d, 0, d, 0, 3, 1, 64'h80000008, 0, 8'h00, 0};
        vt[8]  = '{0, 1, 3'b001, 64'h80000006, 64'hABCD, 0, 0, 0, 0, 2, 1, 64'h80000000, 0, 8'hC0, 64'hABCD000000000000};
        vt[9]  = '{0, 1, 3'b000, 64'h80000001, 64'hFFFFFFFFFFFFFF5A, 0, 0, 0, 0, 2, 1, 64'h80000000, 0, 8'h02, 64'hFFFFFFFFFFFF5A00};
        vt[10] = '{0, 1, 3'b010, 64'h80000004, 64'h12345678, 0, 0, 0, 0, 2, 1, 64'h80000000, 0, 8'hF0, 64'h1234567800000000};
        vt[11] = '{0, 1, 3'b011, 64'h80000000, 64'h0123456789ABCDEF, 0, 0, 0, 0, 2, 1, 64'h80000000, 0, 8'hFF, 64'h0123456789ABCDEF};
        vt[12] = '{0, 0, 3'b010, 64'h80000002, 0, d, 0, 0, 1, 1, 0, 0, 0, 8'h00, 0};
        vt[13] = '{0, 0, 3'b111, 64'h80000000, 0, d, 0, 0, 1, 1, 0, 0, 0, 8'h00, 0};
        vt[14] = '{0, 1, 3'b100, 64'h80000000, 64'h55, 0, 0, 0, 1, 1, 0, 0, 0, 8'h00, 0};
        vt[15] = '{0, 1, 3'b011, 64'h00001000, 64'h77, 0, 0, 0, 0, 1, 0, 0, 0, 8'h00, 0};
        vt[16] = '{0, 0, 3'b000, 64'h7FFFFFFF, 0, d, 0, 0, 0, 1, 0, 0, 0, 8'h00, 0};
        vt[17] = '{0, 1, 3'b001, 64'h80000001, 64'h1234, 0, 0, 0, 1, 1, 0, 0, 0, 8'h00, 0};
        vt[18] = '{1, 0, 3'b011, 64'h80000008, 0, 64'hDEADBEEF, 64'h01234567, 64'h01234567DEADBEEF, 0, 5, 2, 64'h80000008, 64'h8000000C, 8'h00, 0};
        vt[19] = '{1, 0, 3'b000, 64'h80000007, 0, 64'h80112233, 0, 64'hFFFFFFFFFFFFFF80, 0, 3, 1, 64'h80000004, 0, 8'h00, 0};
        vt[20] = '{1, 1, 3'b011, 64'h80000010, 64'h1122334455667788, 0, 0, 0, 0, 3, 2, 64'h80000010, 64'h80000014, 8'h0F, 64'h55667788};
        vt[21] = '{1, 1, 3'b001, 64'h80000006, 64'hABCD, 0, 0, 0, 0, 2, 1, 64'h80000004, 0, 8'h0C, 64'hABCD0000};
        sel = 0; req_valid = 0; req_wr = 0; req_op = 0; req_addr = 0; req_wdata = 0;
        resp_ready = 0; bus_ready = 0; bus_rvalid = 0; bus_rdata = 0;
        repeat (2) tk();
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk($sformatf("rst%0d_req_ready", s), 64'(m_req_ready), 64'd0);
            chk($sformatf("rst%0d_bus_valid", s), 64'(m_bus_valid), 64'd0);
            chk($sformatf("rst%0d_resp", s), {62'd0, m_resp_valid, m_resp_err}, 64'd0);
        end
        rst = 1;
        #1 chk("rst_release_ready", 64'(m_req_ready), 64'd1);
        tk();
        for (int i = 0; i < 22; i++) run(i, vt[i]);
        // response held while core stalls
        sel = 0; req_wr = 1; req_op = 3'b011; req_addr = 64'h1000; req_wdata = 64'h42;
        resp_ready = 0; req_valid = 1;
        tk();
        req_valid = 0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("hold%0d_resp", k), {61'd0, m_resp_valid, m_resp_err, m_req_ready}, 64'd4);
            chk($sformatf("hold%0d_rdata", k), m_resp_rdata, 64'd0);
            chk($sformatf("hold%0d_bus_valid", k), 64'(m_bus_valid), 64'd0);
            tk();
        end
        resp_ready = 1;
        tk();
        chk("hold_release", {62'd0, m_req_ready, m_resp_valid}, 64'd2);
        // bus stall keeps beat stable
        req_wr = 1; req_op = 3'b010; req_addr = 64'h80000004; req_wdata = 64'h11112222;
        bus_ready = 0; req_valid = 1;
        tk();
        req_valid = 0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("stall%0d_valid", k), 64'(m_bus_valid), 64'd1);
            chk($sformatf("stall%0d_addr", k), m_bus_addr, 64'h80000000);
            chk($sformatf("stall%0d_wstrb", k), 64'(m_bus_wstrb), 64'hF0);
            chk($sformatf("stall%0d_wdata", k), m_bus_wdata, 64'h1111222200000000);
            tk();
        end
        bus_ready = 1;
        tk();
        chk("stall_resp", {62'd0, m_resp_valid, m_bus_valid}, 64'd2);
        tk();
        // reset while waiting for read data
        req_wr = 0; req_op = 3'b010; req_addr = 64'h80000000; bus_rvalid = 0; req_valid = 1;
        tk();
        req_valid = 0;
        chk("rstwait_req_beat", 64'(m_bus_valid), 64'd1);
        tk();
        chk("rstwait_in_wait", {62'd0, m_bus_valid, m_resp_valid}, 64'd0);
        rst = 0; bus_rvalid = 1; bus_rdata = 64'hCAFEF00D;
        #1 chk("rstwait_ready_low", 64'(m_req_ready), 64'd0);
        tk();
        chk("rstwait_after_edge", {61'd0, m_bus_valid, m_resp_valid, m_req_ready}, 64'd0);
        tk();
        rst = 1;
        #1 chk("rstwait_ready_back", 64'(m_req_ready), 64'd1);
        repeat (2) tk();
        chk("rstwait_no_late_resp", {61'd0, m_bus_valid, m_resp_valid, m_req_ready}, 64'd1);
        bus_rvalid = 0;
        run(99, vt[5]);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
